// File: rtl/sync_down_timer.sv
// Programmable synchronous down counter/timer: counts a reload value down to zero,
// pulses tc for one cycle on expiry, then either reloads or parks in DONE.
module sync_down_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] reload;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            Q      <= '1;
            reload <= '1;
            tc     <= 1'b0;
        end else if (load) begin
            reload <= load_val;
            Q      <= load_val;
            state  <= IDLE;
            tc     <= 1'b0;
        end else if (start) begin
            Q     <= reload;
            state <= RUN;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (state)
                RUN: begin
                    if (en) begin
                        if (Q != '0) begin
                            Q <= Q - WIDTH'(1);
                        end else begin
                            // Expiry edge: auto_reload is only looked at here.
                            tc <= 1'b1;
                            if (auto_reload) begin
                                Q <= reload;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                end
                IDLE, DONE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pure decodes of the state register, so no input reaches an output combinationally.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: doc/sync_down_timer.md
Name: sync_down_timer

Overview:
- Programmable synchronous down counter and timer. It is the count-down counterpart to the team's synchronous up counter.
- Counts from a loaded reload value down to zero and emits a one-cycle terminal-count pulse.
- Runs either one-shot or auto-reload. Used as a delay/interval generator beside the up counter in the counter library.

Parameters:
WIDTH, 4, bit width of the counter and the reload value

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous active-low reset, sampled on the rising edge of clk
load  input  1  when high, capture load_val into the reload register and Q
load_val  input  WIDTH  value captured on load
start  input  1  begin or restart counting from the reload register
en  input  1  count enable; when low, Q holds
auto_reload  input  1  1 = reload on expiry and keep running; 0 = stop in DONE
Q  output  WIDTH  current count
busy  output  1  high while state is RUN
tc  output  1  registered one-cycle terminal-count pulse
done  output  1  high while state is DONE (one-shot expired)

Behaviour:
- Clocking and reset:
  - Single clock domain; all outputs registered; no combinational input-to-output paths.
  - rst is synchronous and active-low. If rst==0 at a rising edge of clk:
    - state=IDLE, Q={WIDTH{1'b1}}, reload register={WIDTH{1'b1}}
    - busy=0, tc=0, done=0
  - Reset overrides all other inputs and applies from any state, including mid-count.
- States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE).
- Input priority per edge: rst > load > start > counting.
- load=1:
  - reload register<=load_val, Q<=load_val, state<=IDLE, tc<=0.
  - Aborts a RUN and clears DONE.
- start=1, load=0, in any state:
  - Q<=reload register, state<=RUN, tc<=0.
  - Restart in RUN is permitted and produces no tc.
- IDLE: Q holds; tc=0.
- RUN, en=0: Q holds; tc<=0. The expiry is postponed by the number of disabled cycles.
- RUN, en=1, Q!=0: Q<=Q-1, tc<=0.
- RUN, en=1, Q==0 (expiry edge): tc<=1 for exactly one cycle.
  - auto_reload=1: Q<=reload register, stay RUN.
  - auto_reload=0: Q stays 0, state<=DONE.
  - auto_reload is sampled only on the expiry edge.
- Timing:
  - Reload value N gives N+1 enabled cycles from the start edge to the expiry edge; tc is visible in the cycle after the expiry edge.
  - Auto-reload period is N+1 enabled cycles.
  - N=0 with auto_reload=1 makes tc high every enabled cycle.
- No underflow: Q never wraps below 0. Q never exceeds the reload value after start.
- DONE: Q=0, tc=0 after its single pulse. Held until start (goes to RUN) or load (goes to IDLE).
- en is ignored in IDLE and DONE.

Test Plan:
- Reset check: drive rst=0 with start=1 and load=1 for 2 edges -> Q=15, busy=0, done=0, tc=0. Release rst=1 -> Q stays 15 in IDLE.
- One-shot: load 5, then start, en=1, auto_reload=0.
  - Q sequence 5,4,3,2,1,0 on successive edges.
  - tc=1 for exactly one cycle after the 6th edge post-start.
  - Then done=1, busy=0, Q=0 stays held for 10 more cycles with no further tc.
- Auto-reload: load 3, start, en=1, auto_reload=1 -> Q 3,2,1,0,3,2,1,0,...; tc pulses every 4 cycles; busy stays 1; done stays 0.
- Enable gating: reload 4, en low for 3 cycles at Q=2 -> Q holds at 2 throughout, and the tc pulse arrives exactly 3 cycles later than the ungated run.
- Mid-operation events during RUN at Q=6:
  - start -> Q=reload, no tc.
  - load 9 -> Q=9, IDLE, busy=0.
  - rst=0 -> Q=15, IDLE.
  - load and start together -> load wins, state IDLE.
- Boundary: load 0, auto_reload=1, en=1 -> tc high every cycle, Q constant 0. Load 15 one-shot -> tc after 16 enabled cycles, no wrap.
